// File: rtl/coco_ram_arbiter.sv
// Single-port arbiter for the CoCo 64K RAM: VDG > CPU > loader, with loader anti-starvation.
// Optional macro COCO_RAM_WP_EN write-protects the upper half of RAM against CPU writes.
module coco_ram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vdg_req,
    input  logic [ADDR_W-1:0] vdg_addr,
    output logic              vdg_ack,
    output logic [7:0]        vdg_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_wdata,
    output logic              ld_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COMPLETE} state_t;
    localparam logic [1:0] G_VDG = 2'd0, G_CPU = 2'd1, G_LD = 2'd2;
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              wr_q, wr_d;
    logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic              vdg_ack_q, vdg_ack_d, cpu_ack_q, cpu_ack_d, ld_ack_q, ld_ack_d;
    logic [7:0]        vdg_data_q, vdg_data_d, cpu_rdata_q, cpu_rdata_d;
    logic [7:0]        starve_q, starve_d;
    logic              busy_q, busy_d;

    logic              win_vld, win_wr, wp_block, promote;
    logic [1:0]        win;
    logic [ADDR_W-1:0] win_addr;
    logic [7:0]        win_wdata;

    // Winner selection; the loader overtakes the CPU once it has been passed over LIMIT times.
    always_comb begin
        promote   = (starve_q == LIMIT);
        win_vld   = 1'b0;
        win       = G_VDG;
        win_wr    = 1'b0;
        win_addr  = vdg_addr;
        win_wdata = 8'h00;
        if (vdg_req) begin
            win_vld = 1'b1;
        end else if (cpu_req && !(promote && ld_req)) begin
            win_vld   = 1'b1;
            win       = G_CPU;
            win_wr    = cpu_we;
            win_addr  = cpu_addr;
            win_wdata = cpu_wdata;
        end else if (ld_req) begin
            win_vld   = 1'b1;
            win       = G_LD;
            win_wr    = 1'b1;
            win_addr  = ld_addr;
            win_wdata = ld_wdata;
        end
`ifdef COCO_RAM_WP_EN
        wp_block = (win == G_CPU) && win_wr && win_addr[ADDR_W-1];
`else
        wp_block = 1'b0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        vdg_ack_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        ld_ack_d    = 1'b0;
        vdg_data_d  = vdg_data_q;
        cpu_rdata_d = cpu_rdata_q;
        starve_d    = starve_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (!ld_req) begin
                    starve_d = 8'd0;
                end else if (win_vld && win == G_LD) begin
                    starve_d = 8'd0;
                end else if (win_vld && starve_q < LIMIT) begin
                    starve_d = starve_q + 8'd1;
                end
                if (win_vld) begin
                    state_d     = S_ISSUE;
                    gnt_d       = win;
                    wr_d        = win_wr;
                    ram_en_d    = 1'b1;
                    ram_we_d    = win_wr && !wp_block;
                    ram_addr_d  = win_addr;
                    ram_wdata_d = win_wdata;
                    busy_d      = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d   = S_COMPLETE;
                vdg_ack_d = (gnt_q == G_VDG);
                cpu_ack_d = (gnt_q == G_CPU);
                ld_ack_d  = (gnt_q == G_LD);
            end
            S_COMPLETE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (gnt_q == G_VDG) vdg_data_d = ram_rdata;
                if (gnt_q == G_CPU && !wr_q) cpu_rdata_d = ram_rdata;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            gnt_q       <= G_VDG;
            wr_q        <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 8'h00;
            vdg_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ld_ack_q    <= 1'b0;
            vdg_data_q  <= 8'h00;
            cpu_rdata_q <= 8'h00;
            starve_q    <= 8'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            wr_q        <= wr_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            vdg_ack_q   <= vdg_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            ld_ack_q    <= ld_ack_d;
            vdg_data_q  <= vdg_data_d;
            cpu_rdata_q <= cpu_rdata_d;
            starve_q    <= starve_d;
            busy_q      <= busy_d;
        end
    end

    // RAM data arrives during COMPLETE, so it is passed through alongside the ack
    // and held in the register from the next cycle on.
    assign vdg_data  = vdg_ack_q ? ram_rdata : vdg_data_q;
    assign cpu_rdata = (cpu_ack_q && !wr_q) ? ram_rdata : cpu_rdata_q;

    assign vdg_ack   = vdg_ack_q;
    assign cpu_ack   = cpu_ack_q;
    assign ld_ack    = ld_ack_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_coco_ram_arbiter.sv
// Directed bench for coco_ram_arbiter with a synchronous-read RAM model.
module tb_coco_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        vdg_req, cpu_req, cpu_we, ld_req;
    logic [15:0] vdg_addr, cpu_addr, ld_addr;
    logic [7:0]  cpu_wdata, ld_wdata;
    logic        vdg_ack, cpu_ack, ld_ack, ram_en, ram_we, busy;
    logic [7:0]  vdg_data, cpu_rdata, ram_wdata, ram_rdata;
    logic [15:0] ram_addr;

    logic [7:0]  mem [0:65535];
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;

    int errors = 0;
    int checks = 0;
    int who, n;
    logic [7:0] wp_we, wp_mem;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    coco_ram_arbiter #(.ADDR_W(16), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .vdg_req(vdg_req), .vdg_addr(vdg_addr), .vdg_ack(vdg_ack), .vdg_data(vdg_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    // who: 0 = VDG, 1 = CPU, 2 = loader, -1 = no ack within the bound
    task automatic next_ack(output int w);
        w = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (vdg_ack) begin w = 0; break; end
            if (cpu_ack) begin w = 1; break; end
            if (ld_ack)  begin w = 2; break; end
        end
    endtask

    task automatic starve_round(input logic [15:0] la, input logic [7:0] ld, input string tag);
        ld_req = 1'b1; ld_addr = la; ld_wdata = ld;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            next_ack(who);
            if (who != 1) break;
            n++;
        end
        ld_req = 1'b0; cpu_req = 1'b0;
        chk({tag, "_ld_granted"}, who, 2);
        chk({tag, "_cpu_grants"}, n, 8);
        tick();
        chk({tag, "_ld_mem"}, mem[la], ld);
    endtask

    initial begin
`ifdef COCO_RAM_WP_EN
        wp_we = 8'd0; wp_mem = 8'h00;
`else
        wp_we = 8'd1; wp_mem = 8'hAA;
`endif
        reset = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        vdg_req = 0; cpu_req = 0; cpu_we = 0; ld_req = 0;
        vdg_addr = '0; cpu_addr = '0; ld_addr = '0; cpu_wdata = '0; ld_wdata = '0;
        tick(); tick();
        preload(16'h1234, 8'h5A);
        preload(16'h0010, 8'h3C);
        preload(16'h0100, 8'h01);
        preload(16'h0400, 8'h11);
        preload(16'h8000, 8'h00);
        preload(16'hFFFF, 8'hC3);
        chk("reset_ctrl", {vdg_ack, cpu_ack, ld_ack, ram_en, ram_we, busy}, 0);
        chk("reset_data", {ram_addr, ram_wdata, vdg_data}, 0);
        chk("reset_cpu_rdata", cpu_rdata, 0);

        // CPU read of 0x1234
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        tick();
        chk("rd_issue", {ram_en, ram_we, busy, cpu_ack}, 4'b1010);
        chk("rd_addr", ram_addr, 16'h1234);
        cpu_addr = 16'h5555;
        tick();
        chk("rd_ack", {cpu_ack, ram_en}, 2'b10);
        chk("rd_data", cpu_rdata, 8'h5A);
        chk("rd_addr_held", ram_addr, 16'h1234);
        cpu_req = 1'b0;
        tick();
        chk("rd_idle", {cpu_ack, busy}, 2'b00);
        chk("rd_data_hold", cpu_rdata, 8'h5A);

        // simultaneous VDG + CPU
        vdg_req = 1'b1; vdg_addr = 16'h0010;
        cpu_req = 1'b1; cpu_addr = 16'h0100;
        tick();
        chk("sim_vdg_addr", ram_addr, 16'h0010);
        tick();
        chk("sim_vdg_ack", {vdg_ack, cpu_ack}, 2'b10);
        chk("sim_vdg_data", vdg_data, 8'h3C);
        vdg_req = 1'b0;
        tick();
        chk("sim_gap", {vdg_ack, cpu_ack, busy}, 3'b000);
        tick();
        chk("sim_cpu_issue", {ram_en, ram_addr}, {1'b1, 16'h0100});
        tick();
        chk("sim_cpu_ack", {vdg_ack, cpu_ack}, 2'b01);
        chk("sim_cpu_data", cpu_rdata, 8'h01);
        chk("sim_vdg_hold", vdg_data, 8'h3C);
        cpu_req = 1'b0;
        tick();

        // loader starvation, twice to confirm the counter restarts from zero
        starve_round(16'h2000, 8'h77, "starve1");
        starve_round(16'h2001, 8'h78, "starve2");

        // reset during ISSUE of a CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0400; cpu_wdata = 8'hEE;
        tick();
        chk("rst_issue", {ram_en, ram_we}, 2'b11);
        reset = 1'b0;
        #1;
        chk("rst_async", {ram_en, ram_we, busy}, 3'b000);
        tick();
        chk("rst_no_ack", cpu_ack, 0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        reset = 1'b1;
        tick(); tick();
        chk("rst_after", {cpu_ack, busy, ram_en}, 3'b000);
        chk("rst_mem", mem[16'h0400], 8'h11);
        chk("rst_regs", {ram_addr, cpu_rdata}, 0);

        // CPU write to the upper half
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 8'hAA;
        tick();
        chk("wp_cpu_en", {ram_en, ram_wdata}, {1'b1, 8'hAA});
        chk("wp_cpu_we", ram_we, wp_we[0]);
        tick();
        chk("wp_cpu_ack", cpu_ack, 1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        chk("wp_cpu_mem", mem[16'h8000], wp_mem);
        cpu_req = 1'b1;
        tick(); tick();
        chk("wp_cpu_readback", {cpu_ack, cpu_rdata}, {1'b1, wp_mem});
        cpu_req = 1'b0;
        tick();
        ld_req = 1'b1; ld_addr = 16'h8000; ld_wdata = 8'hAA;
        tick();
        chk("wp_ld_we", {ram_en, ram_we}, 2'b11);
        tick();
        chk("wp_ld_ack", ld_ack, 1);
        ld_req = 1'b0;
        tick();
        chk("wp_ld_mem", mem[16'h8000], 8'hAA);

        // all-ones address
        vdg_req = 1'b1; vdg_addr = 16'hFFFF;
        tick();
        chk("max_addr", ram_addr, 16'hFFFF);
        tick();
        chk("max_vdg", {vdg_ack, vdg_data}, {1'b1, 8'hC3});
        vdg_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/coco_ram_arbiter.md
Name: coco_ram_arbiter

Overview:
Single-port arbiter for the 64K system RAM, shared by three requesters: VDG display fetch, 6809 CPU, and the ioctl loader (cassette/cartridge image download into RAM).
- Sits between the SAM address generation and the dpram instance.
- Replaces the current dual-port arrangement with one sequenced port.
- Uses fixed priority with loader anti-starvation, a 3-state access FSM, and a req/ack handshake per requester.

Parameters:
ADDR_W, 16, RAM address width for all requesters and the RAM port.
STARVE_LIMIT, 8, number of grants to other requesters while ld_req is held before the loader is promoted above the CPU (range 1..255).

Ports:
clk  in  1  system clock (57.272 MHz).
reset  in  1  asynchronous, active-low reset.
vdg_req  in  1  VDG read request; held until vdg_ack.
vdg_addr  in  ADDR_W  VDG read address.
vdg_ack  out  1  one-cycle pulse; vdg_data valid in the same cycle.
vdg_data  out  8  registered VDG read data; holds until the next VDG completion.
cpu_req  in  1  CPU request; held until cpu_ack.
cpu_we  in  1  1 = write, 0 = read.
cpu_addr  in  ADDR_W  CPU address.
cpu_wdata  in  8  CPU write data.
cpu_ack  out  1  one-cycle completion pulse.
cpu_rdata  out  8  registered CPU read data; updated only on CPU read completion.
ld_req  in  1  loader write request; held until ld_ack.
ld_addr  in  ADDR_W  loader address.
ld_wdata  in  8  loader write data.
ld_ack  out  1  one-cycle completion pulse.
ram_en  out  1  RAM access strobe.
ram_we  out  1  RAM write enable.
ram_addr  out  ADDR_W  RAM address.
ram_wdata  out  8  RAM write data.
ram_rdata  in  8  RAM read data, valid one clk after ram_en.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
Reset (reset = 0, async):
- FSM goes to IDLE.
- All acks, ram_en, ram_we and busy = 0.
- ram_addr, ram_wdata, vdg_data, cpu_rdata = 0.
- Starvation counter = 0.
- A transaction in flight when reset asserts is aborted: no ack, no write.

FSM states:
- IDLE
  - Requests are sampled only here.
  - If any req is high: latch the winner's id, address, write data and write flag; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle)
  - ram_en = 1, ram_addr and ram_wdata driven from the latched values.
  - ram_we = latched write flag.
  - Go to COMPLETE.
- COMPLETE (exactly 1 cycle)
  - ram_en = ram_we = 0.
  - Capture ram_rdata into vdg_data or cpu_rdata if the access was a read.
  - Pulse the winner's ack.
  - Return to IDLE.

Timing:
- Request seen in IDLE at cycle N → ram_en at N+1 → ack at N+2.
- Sustained throughput: one access per 3 cycles.
- Requesters must deassert req the cycle after ack. A req still high in the next IDLE is treated as a new request.
- Loader transactions are always writes. The VDG is always reads.

Priority (evaluated in IDLE):
- Default order: VDG > CPU > loader.
- If starve_cnt == STARVE_LIMIT: VDG > loader > CPU. VDG is never demoted.

Starvation counter (8-bit, saturating at STARVE_LIMIT):
- +1 on each grant to VDG or CPU while ld_req = 1.
- Cleared on a loader grant.
- Cleared in any IDLE cycle where ld_req = 0.

Boundary cases:
- Simultaneous requests: only one grant per IDLE; losers remain pending with no side effects.
- ram_addr is not truncated or wrapped: address ADDR_W'1s… (all ones) is accessed as-is.
- Request inputs that change outside IDLE are ignored until the next IDLE.

Optional Feature:
Macro: COCO_RAM_WP_EN
- Defined:
  - CPU writes with cpu_addr[ADDR_W-1] = 1 (ROM-shadow half) run the full ISSUE/COMPLETE sequence and return cpu_ack.
  - ram_we is held 0 for these writes; ram_en still pulses.
  - Loader writes are never blocked.
- Undefined: all CPU writes pass to ram_we unchanged.

Test Plan:
- Reset released, CPU read 0x1234 where RAM holds 0x5A → ram_en at cycle 1, cpu_ack and cpu_rdata = 0x5A at cycle 2; all outputs were 0 during reset.
- vdg_req and cpu_req raised in the same cycle → VDG granted first (vdg_ack at +2), CPU granted in the following IDLE (cpu_ack at +5).
- ld_req held with continuous CPU requests, STARVE_LIMIT = 8 → loader granted after exactly 8 CPU grants; counter then reads 0.
- Reset asserted during ISSUE of a CPU write to 0x0400 → no cpu_ack, memory at 0x0400 unchanged, FSM in IDLE after release.
- COCO_RAM_WP_EN defined: CPU write 0xAA to 0x8000 → cpu_ack pulses, ram_we stays 0. Loader write 0xAA to 0x8000 → ram_we = 1.
- Undefined COCO_RAM_WP_EN: CPU write 0xAA to 0x8000 → ram_we = 1; readback returns 0xAA.
